ddr3_rd_burst_ctrl: RTL

Read-burst requester on the DDR3 user-clock side of the read path, directly upstream of `rd_fifo`. Issues fixed-length read bursts over a circular address window and pushes the returned 128-bit beats into `rd_fifo`'s write port. A burst is issued only when the FIFO already has room for the whole burst, so returned data never needs backpressure.

---
 rtl/ddr3_rd_burst_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ddr3_rd_burst_ctrl.sv
// Read-burst requester feeding rd_fifo: issues fixed-length bursts over a circular
// address window, only when the FIFO already has room for the whole burst.
module ddr3_rd_burst_ctrl #(
  parameter int          ADDR_W     = 28,
  parameter int          DATA_W     = 128,
  parameter int          WL_W       = 11,
  parameter int          FIFO_DEPTH = 1024,
  parameter int          BURST_LEN  = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] END_ADDR   = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_start,
  input  logic [WL_W-1:0]   fifo_wr_water_level,
  input  logic              fifo_wr_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  output logic              rready,
  output logic              busy,
  output logic [15:0]       burst_cnt,
  output logic              err
);

  localparam int BEAT_WORDS  = 8;
  localparam int BURST_WORDS = BURST_LEN * BEAT_WORDS;

  localparam logic [WL_W-1:0]   SPACE_LIMIT = WL_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [8:0]        LAST_BEAT   = 9'(BURST_LEN - 1);
  localparam logic [ADDR_W:0]   BURST_STEP  = (ADDR_W+1)'(BURST_WORDS);
  localparam logic [ADDR_W:0]   END_LIMIT   = (ADDR_W+1)'(END_ADDR);
  localparam logic [ADDR_W-1:0] BASE        = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t          state;
  logic [8:0]      beat;
  logic            last_beat;
  logic [ADDR_W:0] next_addr;

  // rready is high exactly in DATA, so it doubles as the beat-accept gate
  assign fifo_wr_en   = rready & rvalid;
  assign fifo_wr_data = fifo_wr_en ? rdata : '0;
  assign arlen        = 8'(BURST_LEN - 1);
  assign last_beat    = (beat == LAST_BEAT);
  assign next_addr    = {1'b0, araddr} + BURST_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      araddr    <= BASE;
      burst_cnt <= '0;
      beat      <= '0;
    end else begin
      if ((rvalid && state != S_DATA) ||
          (fifo_wr_en && fifo_wr_full) ||
          (fifo_wr_en && (rlast != last_beat)))
        err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (rd_start) begin
            state <= S_CHECK;
            busy  <= 1'b1;
          end
        end
        S_CHECK: begin
          if (!rd_start) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (fifo_wr_water_level <= SPACE_LIMIT) begin
            state   <= S_ADDR;
            arvalid <= 1'b1;
          end
        end
        S_ADDR: begin
          if (arvalid && arready) begin
            state   <= S_DATA;
            arvalid <= 1'b0;
            rready  <= 1'b1;
            beat    <= '0;
          end
        end
        S_DATA: begin
          // burst length is fixed; rlast only feeds the error flag
          if (rvalid) begin
            if (last_beat) begin
              state  <= S_DONE;
              rready <= 1'b0;
              beat   <= '0;
            end else begin
              beat <= beat + 9'd1;
            end
          end
        end
        S_DONE: begin
          araddr    <= (next_addr >= END_LIMIT) ? BASE : next_addr[ADDR_W-1:0];
          burst_cnt <= burst_cnt + 16'd1;
          state     <= S_CHECK;
        end
        default: begin
          state   <= S_IDLE;
          arvalid <= 1'b0;
          rready  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
